// File: rtl/ido_yuv422_pack.sv
// 4:4:4 -> 4:2:2 packer for the IDO output path, with framing carried through.
// Build option IDO_YUV422_CHROMA_AVG_EN adds the pair-averaged chroma datapath.
module ido_yuv422_pack #(
    parameter int DW  = 8,
    parameter int RND = 1
) (
    input  logic            pclk,
    input  logic            prst_n,
    input  logic            i_vstr,
    input  logic            i_vend,
    input  logic            i_hstr,
    input  logic            i_hend,
    input  logic            i_dvld,
    input  logic [DW-1:0]   i_y,
    input  logic [DW-1:0]   i_cb,
    input  logic [DW-1:0]   i_cr,
    input  logic            r_en,
    input  logic            r_swap_yc,
    input  logic            r_swap_uv,
    input  logic            r_chroma_avg,
    output logic            o_vstr,
    output logic            o_vend,
    output logic            o_hstr,
    output logic            o_hend,
    output logic            o_dvld,
    output logic [2*DW-1:0] o_data,
    output logic            o_trunc_err
);

    typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_t;

    phase_t          phase_q, phase_d;
    logic            active_q, active_d;
    logic [DW-1:0]   y0_q, y0_d, cb0_q, cb0_d, cr0_q, cr0_d;
    logic            hstr0_q, hstr0_d, vstr0_q, vstr0_d;
    logic            swap_yc_q, swap_yc_d, swap_uv_q, swap_uv_d;
    logic            w1_vld_q, w1_vld_d;
    logic [2*DW-1:0] w1_data_q, w1_data_d;
    logic [3:0]      w1_flags_q, w1_flags_d;   // {vstr, hstr, hend, vend}
    logic            o_dvld_q, o_dvld_d;
    logic [2*DW-1:0] o_data_q, o_data_d;
    logic [3:0]      o_flags_q, o_flags_d;
    logic            trunc_q, trunc_d;

    logic            accept, even_px;
    logic [DW-1:0]   cb_pair, cr_pair, c_a, c_b;
    logic [2*DW-1:0] word0, word1, word_single;

    function automatic logic [2*DW-1:0] pack(input logic swap, input logic [DW-1:0] c,
                                             input logic [DW-1:0] y);
        return swap ? {y, c} : {c, y};
    endfunction

`ifdef IDO_YUV422_CHROMA_AVG_EN
    logic avg_q, avg_d;

    // DW+1-bit sum so that the rounding increment cannot overflow.
    function automatic logic [DW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b} + ((RND != 0) ? {{DW{1'b0}}, 1'b1} : {(DW+1){1'b0}});
        return s[DW:1];
    endfunction

    assign cb_pair = avg_q ? avg2(cb0_q, i_cb) : cb0_q;
    assign cr_pair = avg_q ? avg2(cr0_q, i_cr) : cr0_q;
`else
    logic chroma_avg_unused;
    assign chroma_avg_unused = r_chroma_avg ^ (RND != 0);
    assign cb_pair = cb0_q;
    assign cr_pair = cr0_q;
`endif

    assign accept      = r_en && i_dvld && (active_q || i_hstr);
    assign even_px     = i_hstr || (phase_q == PH_EVEN);
    assign c_a         = swap_uv_q ? cr_pair : cb_pair;
    assign c_b         = swap_uv_q ? cb_pair : cr_pair;
    assign word0       = pack(swap_yc_q, c_a, y0_q);
    assign word1       = pack(swap_yc_q, c_b, i_y);
    assign word_single = pack(r_swap_yc, r_swap_uv ? i_cr : i_cb, i_y);

    always_comb begin
        phase_d    = phase_q;
        active_d   = active_q;
        y0_d       = y0_q;
        cb0_d      = cb0_q;
        cr0_d      = cr0_q;
        hstr0_d    = hstr0_q;
        vstr0_d    = vstr0_q;
        swap_yc_d  = swap_yc_q;
        swap_uv_d  = swap_uv_q;
`ifdef IDO_YUV422_CHROMA_AVG_EN
        avg_d      = avg_q;
`endif
        w1_vld_d   = 1'b0;
        w1_data_d  = w1_data_q;
        w1_flags_d = w1_flags_q;
        o_dvld_d   = 1'b0;
        o_data_d   = '0;
        o_flags_d  = 4'b0000;
        trunc_d    = 1'b0;

        if (w1_vld_q) begin
            o_dvld_d  = 1'b1;
            o_data_d  = w1_data_q;
            o_flags_d = w1_flags_q;
        end

        if (accept) begin
            if (even_px) begin
                trunc_d   = i_hstr && (phase_q == PH_ODD);
                y0_d      = i_y;
                cb0_d     = i_cb;
                cr0_d     = i_cr;
                hstr0_d   = i_hstr;
                vstr0_d   = i_vstr;
                swap_yc_d = r_swap_yc;
                swap_uv_d = r_swap_uv;
`ifdef IDO_YUV422_CHROMA_AVG_EN
                avg_d     = r_chroma_avg;
`endif
                active_d  = 1'b1;
                phase_d   = PH_ODD;
                if (i_hend) begin
                    phase_d  = PH_EVEN;
                    active_d = 1'b0;
                    // A pending word1 owns the output this cycle; queue the lone word behind it.
                    if (w1_vld_q) begin
                        w1_vld_d   = 1'b1;
                        w1_data_d  = word_single;
                        w1_flags_d = {i_vstr, i_hstr, 1'b1, i_vend};
                    end else begin
                        o_dvld_d  = 1'b1;
                        o_data_d  = word_single;
                        o_flags_d = {i_vstr, i_hstr, 1'b1, i_vend};
                    end
                end
            end else begin
                o_dvld_d   = 1'b1;
                o_data_d   = word0;
                o_flags_d  = {vstr0_q, hstr0_q, 2'b00};
                w1_vld_d   = 1'b1;
                w1_data_d  = word1;
                w1_flags_d = {2'b00, i_hend, i_vend};
                phase_d    = PH_EVEN;
                if (i_hend) active_d = 1'b0;
            end
        end

        if (!r_en) begin
            phase_d   = PH_EVEN;
            active_d  = 1'b0;
            w1_vld_d  = 1'b0;
            o_dvld_d  = 1'b0;
            o_data_d  = '0;
            o_flags_d = 4'b0000;
            trunc_d   = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            phase_q    <= PH_EVEN;
            active_q   <= 1'b0;
            y0_q       <= '0;
            cb0_q      <= '0;
            cr0_q      <= '0;
            hstr0_q    <= 1'b0;
            vstr0_q    <= 1'b0;
            swap_yc_q  <= 1'b0;
            swap_uv_q  <= 1'b0;
`ifdef IDO_YUV422_CHROMA_AVG_EN
            avg_q      <= 1'b0;
`endif
            w1_vld_q   <= 1'b0;
            w1_data_q  <= '0;
            w1_flags_q <= 4'b0000;
            o_dvld_q   <= 1'b0;
            o_data_q   <= '0;
            o_flags_q  <= 4'b0000;
            trunc_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            active_q   <= active_d;
            y0_q       <= y0_d;
            cb0_q      <= cb0_d;
            cr0_q      <= cr0_d;
            hstr0_q    <= hstr0_d;
            vstr0_q    <= vstr0_d;
            swap_yc_q  <= swap_yc_d;
            swap_uv_q  <= swap_uv_d;
`ifdef IDO_YUV422_CHROMA_AVG_EN
            avg_q      <= avg_d;
`endif
            w1_vld_q   <= w1_vld_d;
            w1_data_q  <= w1_data_d;
            w1_flags_q <= w1_flags_d;
            o_dvld_q   <= o_dvld_d;
            o_data_q   <= o_data_d;
            o_flags_q  <= o_flags_d;
            trunc_q    <= trunc_d;
        end
    end

    assign o_dvld      = o_dvld_q;
    assign o_data      = o_data_q;
    assign o_vstr      = o_flags_q[3];
    assign o_hstr      = o_flags_q[2];
    assign o_hend      = o_flags_q[1];
    assign o_vend      = o_flags_q[0];
    assign o_trunc_err = trunc_q;

endmodule

// File: tb/tb_ido_yuv422_pack.sv
// Randomised bench for ido_yuv422_pack against a pair-level reference model.
`timescale 1ns/1ps
module tb_ido_yuv422_pack;
    localparam int DW = 8;
`ifdef IDO_YUV422_CHROMA_AVG_EN
    localparam bit AVG_BUILT = 1'b1;
`else
    localparam bit AVG_BUILT = 1'b0;
`endif

    logic pclk, prst_n;
    logic i_vstr, i_vend, i_hstr, i_hend, i_dvld;
    logic [DW-1:0] i_y, i_cb, i_cr;
    logic r_en, r_swap_yc, r_swap_uv, r_chroma_avg;
    logic o_vstr, o_vend, o_hstr, o_hend, o_dvld, o_trunc_err;
    logic [2*DW-1:0] o_data;

    ido_yuv422_pack #(.DW(DW), .RND(1)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .i_vstr(i_vstr), .i_vend(i_vend), .i_hstr(i_hstr), .i_hend(i_hend), .i_dvld(i_dvld),
        .i_y(i_y), .i_cb(i_cb), .i_cr(i_cr),
        .r_en(r_en), .r_swap_yc(r_swap_yc), .r_swap_uv(r_swap_uv), .r_chroma_avg(r_chroma_avg),
        .o_vstr(o_vstr), .o_vend(o_vend), .o_hstr(o_hstr), .o_hend(o_hend),
        .o_dvld(o_dvld), .o_data(o_data), .o_trunc_err(o_trunc_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected words as {vstr,hstr,hend,vend,data[15:0]}
    logic [19:0] exp_q[$];
    bit m_line_open, m_have_even;
    logic [7:0] e_y, e_cb, e_cr;
    bit e_hstr, e_vstr, e_syc, e_suv, e_avg;
    int trunc_exp = 0;
    int trunc_seen = 0;
    int word_idx = 0;

    function automatic logic [15:0] pk(input bit syc, input logic [7:0] c, input logic [7:0] y);
        return syc ? {y, c} : {c, y};
    endfunction

    function automatic logic [7:0] mavg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return s[7:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_line_open = 0;
        m_have_even = 0;
    endtask

    task automatic model_pix(input bit vs, input bit hs, input bit he, input bit ve,
                             input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        logic [7:0] cbv, crv, first, second;
        if (!r_en) return;
        if (!(m_line_open || hs)) return;
        if (hs) begin
            if (m_have_even) trunc_exp++;
            m_have_even = 0;
            m_line_open = 1;
        end
        if (!m_have_even) begin
            if (he) begin
                exp_q.push_back({vs, hs, 1'b1, ve, pk(r_swap_yc, r_swap_uv ? cr : cb, y)});
                m_line_open = 0;
            end else begin
                e_y = y; e_cb = cb; e_cr = cr; e_hstr = hs; e_vstr = vs;
                e_syc = r_swap_yc; e_suv = r_swap_uv; e_avg = r_chroma_avg && AVG_BUILT;
                m_have_even = 1;
            end
        end else begin
            cbv = e_avg ? mavg(e_cb, cb) : e_cb;
            crv = e_avg ? mavg(e_cr, cr) : e_cr;
            first  = e_suv ? crv : cbv;
            second = e_suv ? cbv : crv;
            exp_q.push_back({e_vstr, e_hstr, 2'b00, pk(e_syc, first, e_y)});
            exp_q.push_back({2'b00, he, ve, pk(e_syc, second, y)});
            m_have_even = 0;
            if (he) m_line_open = 0;
        end
    endtask

    always @(negedge pclk) begin
        if (prst_n) begin
            if (o_trunc_err) trunc_seen++;
            if (o_dvld) begin
                if (exp_q.size() == 0)
                    check("unexpected_word", {11'd1, o_vstr, o_hstr, o_hend, o_vend, o_data}, 32'd0);
                else
                    check($sformatf("word%0d", word_idx),
                          {12'd0, o_vstr, o_hstr, o_hend, o_vend, o_data}, {12'd0, exp_q.pop_front()});
                word_idx++;
            end else if ({o_vstr, o_hstr, o_hend, o_vend} != 4'b0000) begin
                check("flag_without_dvld", {28'd0, o_vstr, o_hstr, o_hend, o_vend}, 32'd0);
            end
        end
    end

    task automatic pix(input bit vs, input bit hs, input bit he, input bit ve,
                       input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        i_vstr = vs; i_hstr = hs; i_hend = he; i_vend = ve;
        i_y = y; i_cb = cb; i_cr = cr; i_dvld = 1'b1;
        model_pix(vs, hs, he, ve, y, cb, cr);
        @(posedge pclk); #1;
        i_dvld = 1'b0; i_vstr = 0; i_hstr = 0; i_hend = 0; i_vend = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    task automatic drain(input string tag);
        idle(4);
        check({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    task automatic cfg(input bit syc, input bit suv, input bit avg);
        r_swap_yc = syc; r_swap_uv = suv; r_chroma_avg = avg;
    endtask

    task automatic spec_line();
        pix(0, 1, 0, 0, 8'd10, 8'd100, 8'd200);
        pix(0, 0, 0, 0, 8'd20, 8'd101, 8'd203);
    endtask

    initial begin
        int w;
        bit tr;
        logic [7:0] cexp;
        prst_n = 0; r_en = 1; cfg(0, 0, 0);
        i_vstr = 0; i_vend = 0; i_hstr = 0; i_hend = 0; i_dvld = 0;
        i_y = 0; i_cb = 0; i_cr = 0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_dvld", o_dvld, 0);
        check("rst_data", o_data, 0);
        check("rst_flags", {o_vstr, o_hstr, o_hend, o_vend}, 0);
        check("rst_trunc", o_trunc_err, 0);
        prst_n = 1;
        idle(2);

        // Reference line, averaged, no swaps
        cfg(0, 0, 1);
        spec_line();
        cexp = AVG_BUILT ? 8'd101 : 8'd100;
        check("t1_word0_T1", {o_dvld, o_hstr, o_data}, {2'b11, cexp, 8'd10});
        pix(0, 0, 0, 0, 8'd30, 8'd50, 8'd7);
        pix(0, 0, 1, 0, 8'd40, 8'd51, 8'd8);
        drain("t1");

        // Same line, both swaps, no averaging
        cfg(1, 1, 0);
        spec_line();
        check("t2_word0_T1", o_data, 16'h0AC8);
        pix(0, 0, 0, 0, 8'd30, 8'd50, 8'd7);
        pix(0, 0, 1, 0, 8'd40, 8'd51, 8'd8);
        drain("t2");

        // Odd-width line, continuous then with a gap before the last pixel
        cfg(0, 0, 1);
        pix(0, 1, 0, 0, 8'd1, 8'd2, 8'd3);
        pix(0, 0, 0, 0, 8'd3, 8'd4, 8'd5);
        pix(0, 0, 1, 0, 8'd5, 8'd9, 8'd77);
        pix(0, 0, 0, 0, 8'd6, 8'd6, 8'd6);
        pix(0, 0, 0, 0, 8'd7, 8'd7, 8'd7);
        drain("t3a");
        pix(0, 1, 0, 0, 8'd1, 8'd2, 8'd3);
        pix(0, 0, 0, 0, 8'd3, 8'd4, 8'd5);
        idle(3);
        pix(0, 0, 1, 0, 8'd5, 8'd9, 8'd77);
        check("t3b_single_T1", {o_dvld, o_hend, o_data}, {2'b11, 16'h0905});
        drain("t3b");

        // Truncated line: hstr after a single EVEN pixel
        pix(0, 1, 0, 0, 8'd50, 8'd60, 8'd70);
        pix(0, 1, 0, 0, 8'd51, 8'd61, 8'd71);
        check("t4_trunc_T1", {o_trunc_err, o_dvld}, 2'b10);
        pix(0, 0, 1, 0, 8'd52, 8'd62, 8'd72);
        check("t4_trunc_once", o_trunc_err, 0);
        drain("t4");

        // Gapped input, saturating chroma average and fixed latencies
        cfg(0, 0, 1);
        pix(0, 1, 0, 0, 8'h11, 8'hFF, 8'h80);
        idle(1);
        check("t5_no_even_out", o_dvld, 0);
        pix(0, 0, 1, 0, 8'h22, 8'hFF, 8'h40);
        check("t5_word0_lat1", {o_dvld, o_data}, {1'b1, 16'hFF11});
        @(posedge pclk); #1;
        cexp = AVG_BUILT ? 8'h60 : 8'h80;
        check("t5_word1_lat2", {o_dvld, o_hend, o_data}, {2'b11, cexp, 8'h22});
        @(posedge pclk); #1;
        check("t5_quiet", o_dvld, 0);
        drain("t5");

        // Randomised frames with per-pixel register changes
        for (int ln = 0; ln < 60; ln++) begin
            w  = $urandom_range(1, 8);
            tr = ($urandom_range(0, 5) == 0);
            for (int p = 0; p < w; p++) begin
                cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
                pix((p == 0) && (ln % 10 == 0), p == 0, (p == w-1) && !tr,
                    (p == w-1) && !tr && (ln % 10 == 9),
                    8'($urandom), 8'($urandom), 8'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            if (!tr && $urandom_range(0, 3) == 0)
                pix(0, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        pix(0, 1, 0, 0, 8'd1, 8'd1, 8'd1);
        pix(0, 0, 1, 1, 8'd2, 8'd2, 8'd2);
        drain("rand");

        // Asynchronous reset mid-pair
        cfg(0, 0, 0);
        pix(0, 1, 0, 0, 8'd90, 8'd91, 8'd92);
        pix(0, 0, 0, 0, 8'd93, 8'd94, 8'd95);
        #2 prst_n = 0;
        #1;
        check("t6_rst_dvld", o_dvld, 0);
        check("t6_rst_data", o_data, 0);
        model_reset();
        @(posedge pclk); @(posedge pclk); #1;
        prst_n = 1;
        pix(0, 0, 0, 0, 8'd11, 8'd12, 8'd13);
        pix(0, 0, 1, 0, 8'd14, 8'd15, 8'd16);
        check("t6_ignored_pre_hstr", o_dvld, 0);
        pix(0, 1, 0, 0, 8'd21, 8'd22, 8'd23);
        pix(0, 0, 1, 0, 8'd24, 8'd25, 8'd26);
        drain("t6");

        // Enable dropped with a pair in flight
        pix(0, 1, 0, 0, 8'd31, 8'd32, 8'd33);
        pix(0, 0, 0, 0, 8'd34, 8'd35, 8'd36);
        r_en = 0;
        @(posedge pclk); #1;
        model_reset();
        check("t7_en_dvld", o_dvld, 0);
        check("t7_en_data", o_data, 0);
        pix(0, 1, 0, 0, 8'd41, 8'd42, 8'd43);
        check("t7_idle_dvld", o_dvld, 0);
        r_en = 1;
        pix(0, 0, 0, 0, 8'd44, 8'd45, 8'd46);
        pix(0, 1, 0, 0, 8'd47, 8'd48, 8'd49);
        pix(0, 0, 1, 0, 8'd50, 8'd51, 8'd52);
        drain("t7");

        check("trunc_count", trunc_seen, trunc_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
